// File: rtl/restoring_div_ctrl.sv
// Restoring divider sequencer with a shared SIZE+1 bit add/subtract unit.
// Optional RDIV_DBZ_EN adds a dbz port and a one-cycle divide-by-zero shortcut.

module AddSub #(
  parameter int size = 6
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            mode,
  output logic [size-1:0] sum,
  output logic            cout
);
  logic [size:0] full;

  // mode=1 computes a-b as a+~b+1; cout=1 then means no borrow
  assign full = {1'b0, a} + {1'b0, (mode ? ~b : b)} + {{size{1'b0}}, mode};
  assign sum  = full[size-1:0];
  assign cout = full[size];
endmodule

// state   | meaning
// IDLE    | ready for a new start
// SHIFT   | shift {A,Q} left by one
// SUB     | A <= A-M, set quotient bit on success
// RESTORE | A <= A+M after a borrow
// DONE    | results valid, done pulse
module restoring_div_ctrl #(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            ready,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder
`ifdef RDIV_DBZ_EN
  ,
  output logic            dbz
`endif
);
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SUB,
    S_RESTORE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE:0]   a_q, a_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] quot_q, quot_d;
  logic [SIZE-1:0] rem_q, rem_d;
`ifdef RDIV_DBZ_EN
  logic            dbz_q, dbz_d;
`endif

  logic [SIZE:0]   as_sum;
  logic            as_cout;
  logic            as_mode;

  assign as_mode = (state_q == S_SUB);

  AddSub #(.size(SIZE + 1)) u_addsub (
    .a    (a_q),
    .b    ({1'b0, m_q}),
    .mode (as_mode),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef RDIV_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef RDIV_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef RDIV_DBZ_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = '0;
          q_d     = dividend;
          m_d     = divisor;
          cnt_d   = CW'(SIZE);
          state_d = S_SHIFT;
`ifdef RDIV_DBZ_EN
          dbz_d   = (divisor == '0);
          if (divisor == '0) begin
            q_d     = '1;
            a_d     = {1'b0, dividend};
            state_d = S_DONE;
          end
`endif
        end
      end
      S_SHIFT: begin
        a_d     = {a_q[SIZE-1:0], q_q[SIZE-1]};
        q_d     = {q_q[SIZE-2:0], 1'b0};
        state_d = S_SUB;
      end
      S_SUB: begin
        a_d = as_sum;
        if (as_cout) begin
          q_d     = {q_q[SIZE-1:1], 1'b1};
          cnt_d   = cnt_q - CW'(1);
          state_d = (cnt_q == CW'(1)) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_RESTORE;
        end
      end
      S_RESTORE: begin
        a_d     = as_sum;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        quot_d  = q_q;
        rem_d   = a_q[SIZE-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Results are visible straight from the working registers during DONE
  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign quotient  = done ? q_q : quot_q;
  assign remainder = done ? a_q[SIZE-1:0] : rem_q;
`ifdef RDIV_DBZ_EN
  assign dbz       = dbz_q;
`endif
endmodule
